// File: rtl/mac_int8_out_acc.sv
// mac_int8_out_acc: per-lane group accumulation and INT8 requantization
// for the packed three-lane MAC result, with a 2-deep credit-managed FIFO.
// Ports: clk, clr (sync, active high); in_valid/in_ready/in_first/in_last
// and result_h/result_l input beats; cfg_bias/cfg_mult/cfg_shift/cfg_relu
// requant config; out_valid/out_ready/out_data/out_sat result stream.
module mac_int8_out_acc #(
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 5
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [36:0]          result_h,
  input  logic [37:0]          result_l,
  input  logic [3*ACC_W-1:0]   cfg_bias,
  input  logic [15:0]          cfg_mult,
  input  logic [SHIFT_W-1:0]   cfg_shift,
  input  logic                 cfg_relu,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [23:0]          out_data,
  output logic [2:0]           out_sat
);

  localparam int P_W = ACC_W + 17;
  localparam int R_W = P_W + 1;

  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  localparam logic signed [R_W-1:0] Q_MAX =
    {{(R_W-8){1'b0}}, 8'h7f};
  localparam logic signed [R_W-1:0] Q_MIN =
    {{(R_W-8){1'b1}}, 8'h80};

  // Returns {overflow, saturated sum}.
  function automatic logic [ACC_W:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b
  );
    logic [ACC_W:0]   sum;
    logic             ovf;
    logic [ACC_W-1:0] res;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    ovf = sum[ACC_W] ^ sum[ACC_W-1];
    if (ovf) begin
      res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      res = sum[ACC_W-1:0];
    end
    return {ovf, res};
  endfunction

  // ---------------- lane unpack ----------------
  logic [24:0]      lane_raw [3];
  logic [ACC_W-1:0] lane     [3];

  assign lane_raw[0] = result_l[24:0];
  assign lane_raw[1] = {result_h[11:0], result_l[37:25]};
  assign lane_raw[2] = result_h[36:12];

  // ---------------- accumulate stage ----------------
  logic [ACC_W-1:0] acc_q    [3];
  logic [ACC_W-1:0] acc_d    [3];
  logic [ACC_W:0]   acc_sum  [3];
  logic [2:0]       accsat_q;
  logic [2:0]       accsat_d;
  logic             beat;

  assign beat = in_valid && in_ready;

  always_comb begin
    accsat_d = accsat_q;
    for (int i = 0; i < 3; i++) begin
      lane[i] = {{(ACC_W-25){lane_raw[i][24]}}, lane_raw[i]};
      acc_sum[i] = sat_add(
        in_first ? {ACC_W{1'b0}} : acc_q[i], lane[i]);
      acc_d[i] = acc_q[i];
      if (beat) begin
        acc_d[i] = acc_sum[i][ACC_W-1:0];
        accsat_d[i] = (in_first ? 1'b0 : accsat_q[i])
                    | acc_sum[i][ACC_W];
      end
    end
  end

  // ---------------- R1: bias + multiply ----------------
  // acc_q still holds the finished group during R1, even if the
  // next group's first beat is accepted in the same cycle.
  logic             r1_v_q;
  logic             r1_v_d;
  logic [ACC_W:0]   bsum     [3];
  logic [P_W-1:0]   prod_d   [3];
  logic [P_W-1:0]   mult_ext;
  logic [2:0]       r1sat;

  assign r1_v_d   = beat && in_last;
  assign mult_ext = {{(ACC_W+1){1'b0}}, cfg_mult};

  always_comb begin
    r1sat = '0;
    for (int i = 0; i < 3; i++) begin
      bsum[i] = sat_add(acc_q[i],
                        cfg_bias[ACC_W*i +: ACC_W]);
      // Modular product of sign-extended operands is exact here.
      prod_d[i] = {{17{bsum[i][ACC_W-1]}},
                   bsum[i][ACC_W-1:0]} * mult_ext;
      r1sat[i] = accsat_q[i] | bsum[i][ACC_W];
    end
  end

  // ---------------- R2: round, shift, relu, clamp ----------------
  logic                    r2_v_q;
  logic [P_W-1:0]          prod_q   [3];
  logic [2:0]              r2sat_q;
  logic [R_W-1:0]          rnd;
  logic [R_W-1:0]          rsum     [3];
  logic signed [R_W-1:0]   rq       [3];
  logic [7:0]              q8       [3];
  logic [2:0]              clip;
  logic [26:0]             push_word;

  // Half an LSB of the shifted result; zero when shift is zero.
  assign rnd = ({{P_W{1'b0}}, 1'b1} << cfg_shift) >> 1;

  always_comb begin
    clip = '0;
    for (int i = 0; i < 3; i++) begin
      rsum[i] = {prod_q[i][P_W-1], prod_q[i]} + rnd;
      rq[i]   = $signed(rsum[i]) >>> cfg_shift;
      if (cfg_relu && rq[i][R_W-1]) begin
        rq[i] = '0;
      end
      if (rq[i] > Q_MAX) begin
        q8[i]   = 8'h7f;
        clip[i] = 1'b1;
      end else if (rq[i] < Q_MIN) begin
        q8[i]   = 8'h80;
        clip[i] = 1'b1;
      end else begin
        q8[i]   = rq[i][7:0];
      end
    end
    push_word = {r2sat_q | clip, q8[2], q8[1], q8[0]};
  end

  // ---------------- output FIFO ----------------
  logic [26:0] mem_q [2];
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic        wr_q;
  logic        wr_d;
  logic        rd_q;
  logic        rd_d;
  logic        push;
  logic        pop;
  logic [2:0]  outstanding;

  assign push = r2_v_q;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_d = push ? ~wr_q : wr_q;
    rd_d = pop  ? ~rd_q : rd_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Credits cover FIFO entries plus groups still in R1/R2, so a
  // push can never find the FIFO full.
  assign outstanding = {1'b0, cnt_q}
                     + {2'b00, r1_v_q}
                     + {2'b00, r2_v_q};
  assign in_ready  = !clr && (outstanding < 3'd2);

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? mem_q[rd_q][23:0] : 24'h0;
  assign out_sat   = out_valid ? mem_q[rd_q][26:24] : 3'b000;

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 3; i++) begin
        acc_q[i]  <= '0;
        prod_q[i] <= '0;
      end
      accsat_q <= '0;
      r1_v_q   <= 1'b0;
      r2_v_q   <= 1'b0;
      r2sat_q  <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= acc_d[i];
      end
      accsat_q <= accsat_d;
      r1_v_q   <= r1_v_d;
      r2_v_q   <= r1_v_q;
      if (r1_v_q) begin
        for (int i = 0; i < 3; i++) begin
          prod_q[i] <= prod_d[i];
        end
        r2sat_q <= r1sat;
      end
      if (push) begin
        mem_q[wr_q] <= push_word;
      end
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: tb/tb_mac_int8_out_acc.sv
// Testbench for mac_int8_out_acc: directed scenarios plus randomized
// groups checked against a plain-arithmetic model.
module tb_mac_int8_out_acc;

  localparam int ACC_W   = 26;
  localparam int SHIFT_W = 5;
  localparam longint AMAX = (64'sd1 <<< (ACC_W-1)) - 64'sd1;
  localparam longint AMIN = -(64'sd1 <<< (ACC_W-1));

  logic               clk = 1'b0;
  logic               clr;
  logic               in_valid;
  logic               in_ready;
  logic               in_first;
  logic               in_last;
  logic [36:0]        result_h;
  logic [37:0]        result_l;
  logic [3*ACC_W-1:0] cfg_bias;
  logic [15:0]        cfg_mult;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               cfg_relu;
  logic               out_valid;
  logic               out_ready;
  logic [23:0]        out_data;
  logic [2:0]         out_sat;

  int n_tests = 0;
  int n_fail  = 0;

  longint m_acc [3];
  bit     m_sat [3];
  longint m_bias [3];
  longint m_mult;
  int     m_shift;
  bit     m_relu;
  logic [26:0] exp_q [$];

  mac_int8_out_acc #(.ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .result_h(result_h), .result_l(result_l),
    .cfg_bias(cfg_bias), .cfg_mult(cfg_mult),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic set_cfg(input longint b0, b1, b2,
                         input int mult, input int sh,
                         input bit relu);
    logic [ACC_W-1:0] t0, t1, t2;
    m_bias[0] = b0; m_bias[1] = b1; m_bias[2] = b2;
    m_mult = mult; m_shift = sh; m_relu = relu;
    t0 = b0[ACC_W-1:0];
    t1 = b1[ACC_W-1:0];
    t2 = b2[ACC_W-1:0];
    cfg_bias  = {t2, t1, t0};
    cfg_mult  = mult[15:0];
    cfg_shift = sh[SHIFT_W-1:0];
    cfg_relu  = relu;
  endtask

  task automatic set_beat(input bit f, input bit l,
                          input int l0, l1, l2);
    logic [24:0] a, b, c;
    a = l0[24:0]; b = l1[24:0]; c = l2[24:0];
    result_l = {b[12:0], a};
    result_h = {c, b[24:13]};
    in_first = f;
    in_last  = l;
  endtask

  // Starts and ends just after a rising edge.
  task automatic send_beat(input bit f, input bit l,
                           input int l0, l1, l2,
                           output bit ok);
    set_beat(f, l, l0, l1, l2);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_beat_timeout in_ready stuck %0b want 1",
               in_ready);
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference: saturating group sum, then requant by plain arithmetic.
  task automatic model_beat(input bit f, input bit l,
                            input int l0, l1, l2);
    int ln [3];
    longint s, p, r;
    bit sat;
    logic [26:0] w;
    logic [7:0] rb;
    ln[0] = l0; ln[1] = l1; ln[2] = l2;
    for (int i = 0; i < 3; i++) begin
      if (f) begin
        m_acc[i] = 0;
        m_sat[i] = 1'b0;
      end
      m_acc[i] = m_acc[i] + ln[i];
      if (m_acc[i] > AMAX) begin
        m_acc[i] = AMAX; m_sat[i] = 1'b1;
      end else if (m_acc[i] < AMIN) begin
        m_acc[i] = AMIN; m_sat[i] = 1'b1;
      end
    end
    if (l) begin
      w = '0;
      for (int i = 0; i < 3; i++) begin
        sat = m_sat[i];
        s = m_acc[i] + m_bias[i];
        if (s > AMAX) begin
          s = AMAX; sat = 1'b1;
        end else if (s < AMIN) begin
          s = AMIN; sat = 1'b1;
        end
        p = s * m_mult;
        if (m_shift > 0) p = p + (64'sd1 <<< (m_shift-1));
        r = p >>> m_shift;
        if (m_relu && r < 0) r = 0;
        if (r > 127) begin
          r = 127; sat = 1'b1;
        end else if (r < -128) begin
          r = -128; sat = 1'b1;
        end
        rb = r[7:0];
        w[8*i +: 8] = rb;
        w[24+i] = sat;
      end
      exp_q.push_back(w);
    end
  endtask

  function automatic int rnd_lane();
    if ($urandom_range(0, 7) == 0)
      return int'($urandom_range(0, 33554431)) - 16777216;
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready got %0b want 0", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid got %0b want 0", out_valid);
    end
    n_tests++;
    if (out_data !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_out_data got %h want 0", out_data);
    end
    n_tests++;
    if (out_sat !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_out_sat got %b want 000", out_sat);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ready got %0b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic v1, v2, v3;
    set_cfg(0, 0, 0, 1, 0, 0);
    out_ready = 1'b1;
    set_beat(1'b1, 1'b1, 100, -50, 3);
    in_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_in_ready got %0b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); v1 = out_valid;
    @(negedge clk); v2 = out_valid;
    @(negedge clk); v3 = out_valid;
    n_tests++;
    if ({v1, v2, v3} !== 3'b001) begin
      n_fail++;
      $display("FAIL single_latency got %b want 001",
               {v1, v2, v3});
    end
    n_tests++;
    if (out_data !== 24'h03CE64) begin
      n_fail++;
      $display("FAIL single_data got %h want 03ce64", out_data);
    end
    n_tests++;
    if (out_sat !== 3'b000) begin
      n_fail++;
      $display("FAIL single_sat got %b want 000", out_sat);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop got %0b want 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_multi_beat();
    bit ok;
    bit early;
    set_cfg(40, 0, 0, 2, 1, 0);
    out_ready = 1'b1;
    send_beat(1'b1, 1'b0, 10, 0, 0, ok);
    send_beat(1'b0, 1'b0, 20, 0, 0, ok);
    early = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) early = 1'b1;
    end
    @(posedge clk); #1;
    n_tests++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_early got %0b want 0", early);
    end
    send_beat(1'b0, 1'b1, 30, 0, 0, ok);
    wait_out(ok);
    n_tests++;
    if (!ok || out_data !== 24'h000064) begin
      n_fail++;
      $display("FAIL multi_data got %h want 000064", out_data);
    end
    n_tests++;
    if (out_sat !== 3'b000) begin
      n_fail++;
      $display("FAIL multi_sat got %b want 000", out_sat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_relu();
    bit ok;
    logic [23:0] want [2];
    want[0] = 24'h029071;
    want[1] = 24'h020071;
    out_ready = 1'b1;
    for (int rl = 0; rl < 2; rl++) begin
      set_cfg(0, 0, 0, 3, 3, rl[0]);
      send_beat(1'b1, 1'b1, 300, -300, 4, ok);
      wait_out(ok);
      n_tests++;
      if (!ok || out_data !== want[rl]) begin
        n_fail++;
        $display("FAIL round_relu%0d got %h want %h",
                 rl, out_data, want[rl]);
      end
      n_tests++;
      if (out_sat !== 3'b000) begin
        n_fail++;
        $display("FAIL round_relu%0d_sat got %b want 000",
                 rl, out_sat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    bit ok;
    set_cfg(0, 0, 0, 1, 0, 0);
    out_ready = 1'b1;
    send_beat(1'b1, 1'b0, 16777215, 0, 0, ok);
    send_beat(1'b0, 1'b0, 16777215, 0, 0, ok);
    send_beat(1'b0, 1'b1, 16777215, 0, 0, ok);
    wait_out(ok);
    n_tests++;
    if (!ok || out_data !== 24'h00007F) begin
      n_fail++;
      $display("FAIL sat_data got %h want 00007f", out_data);
    end
    n_tests++;
    if (out_sat !== 3'b001) begin
      n_fail++;
      $display("FAIL sat_flags got %b want 001", out_sat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen_ready;
    bit pending;
    bit drop;
    int got;
    int acc_at;
    logic [23:0] want;
    set_cfg(0, 0, 0, 1, 0, 0);
    out_ready = 1'b0;
    send_beat(1'b1, 1'b1, 11, 0, 0, ok);
    send_beat(1'b1, 1'b1, 22, 0, 0, ok);
    set_beat(1'b1, 1'b1, 33, 0, 0);
    in_valid = 1'b1;
    seen_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (in_ready) seen_ready = 1'b1;
    end
    n_tests++;
    if (seen_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready got 1 want 0");
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 24'h00000B) begin
      n_fail++;
      $display("FAIL bp_head got v%0b %h want v1 00000b",
               out_valid, out_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    got = 0;
    acc_at = -1;
    pending = 1'b1;
    for (int k = 0; k < 40 && (got < 3 || pending); k++) begin
      @(negedge clk);
      drop = 1'b0;
      if (pending && in_ready) begin
        acc_at = got;
        drop = 1'b1;
      end
      if (out_valid && got < 3) begin
        want = (got == 0) ? 24'h00000B :
               (got == 1) ? 24'h000016 : 24'h000021;
        n_tests++;
        if (out_data !== want) begin
          n_fail++;
          $display("FAIL bp_out%0d got %h want %h",
                   got, out_data, want);
        end
        got++;
      end
      @(posedge clk); #1;
      if (drop) begin
        in_valid = 1'b0;
        pending = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL bp_count got %0d want 3", got);
    end
    n_tests++;
    if (acc_at < 1) begin
      n_fail++;
      $display("FAIL bp_third_accept pops %0d want >=1", acc_at);
    end
  endtask

  task automatic test_reset_midgroup();
    bit ok;
    set_cfg(0, 0, 0, 1, 0, 0);
    out_ready = 1'b0;
    send_beat(1'b1, 1'b1, 99, 0, 0, ok);
    send_beat(1'b1, 1'b0, 50, 0, 0, ok);
    send_beat(1'b0, 1'b0, 50, 0, 0, ok);
    wait_out(ok);
    n_tests++;
    if (!ok || out_data !== 24'h000063) begin
      n_fail++;
      $display("FAIL rst_pre got %h want 000063", out_data);
    end
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_ready got %0b want 0", in_ready);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 24'h0 ||
        out_sat !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_outputs got v%0b %h %b want v0 0 000",
               out_valid, out_data, out_sat);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready_after got %0b want 1", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(1'b0, 1'b1, 7, 0, 0, ok);
    wait_out(ok);
    n_tests++;
    if (!ok || out_data !== 24'h000007) begin
      n_fail++;
      $display("FAIL rst_group got %h want 000007", out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int ng;
    for (int rnd = 0; rnd < 4; rnd++) begin
      int got;
      ng = 30;
      got = 0;
      exp_q.delete();
      if ($urandom_range(0, 3) == 0)
        set_cfg(int'($urandom_range(0, 67108863)) - 33554432,
                int'($urandom_range(0, 10000)) - 5000,
                int'($urandom_range(0, 10000)) - 5000,
                int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)));
      else
        set_cfg(int'($urandom_range(0, 10000)) - 5000,
                int'($urandom_range(0, 10000)) - 5000,
                int'($urandom_range(0, 10000)) - 5000,
                int'($urandom_range(0, 300)),
                int'($urandom_range(0, 12)),
                1'($urandom_range(0, 1)));
      fork
        begin
          bit ok;
          int len;
          int l0, l1, l2;
          for (int g = 0; g < ng; g++) begin
            len = int'($urandom_range(1, 4));
            for (int b = 0; b < len; b++) begin
              if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
              end
              l0 = rnd_lane(); l1 = rnd_lane(); l2 = rnd_lane();
              send_beat(b == 0, b == len-1, l0, l1, l2, ok);
              if (ok) model_beat(b == 0, b == len-1, l0, l1, l2);
            end
          end
        end
        begin
          bit held;
          logic [23:0] pd;
          logic [2:0] ps;
          logic [26:0] w;
          held = 1'b0;
          pd = '0;
          ps = '0;
          for (int k = 0; k < 4000 && got < ng; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && held) begin
              n_tests++;
              if (out_data !== pd || out_sat !== ps) begin
                n_fail++;
                $display("FAIL rnd_hold got %h/%b want %h/%b",
                         out_data, out_sat, pd, ps);
              end
            end
            if (out_valid && out_ready) begin
              n_tests++;
              if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rnd_extra got %h want none",
                         out_data);
              end else begin
                w = exp_q.pop_front();
                if ({out_sat, out_data} !== w) begin
                  n_fail++;
                  $display("FAIL rnd_out%0d got %b/%h want %b/%h",
                           got, out_sat, out_data,
                           w[26:24], w[23:0]);
                end
              end
              got++;
            end
            held = out_valid && !out_ready;
            pd = out_data;
            ps = out_sat;
            @(posedge clk); #1;
          end
        end
      join
      out_ready = 1'b1;
      n_tests++;
      if (got != ng || exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL rnd_round%0d got %0d left %0d want %0d 0",
                 rnd, got, exp_q.size(), ng);
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
    result_h = '0;
    result_l = '0;
    out_ready = 1'b0;
    set_cfg(0, 0, 0, 1, 0, 0);
    test_reset();
    test_single();
    test_multi_beat();
    test_round_relu();
    test_saturation();
    test_backpressure();
    test_reset_midgroup();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_int8_out_acc.md
# mac_int8_out_acc

Downstream companion to the INT8 dot-product MAC tile. It consumes the MAC's packed three-lane 25-bit accumulator output (`result_h`/`result_l`) and accumulates each lane across K-chunk beats into a wider saturating accumulator. At the end of a group it applies per-lane bias, a fixed-point multiplier, a rounding right shift, optional ReLU and INT8 clamping. Results are emitted as three INT8 values through a 2-entry valid/ready output FIFO.

## Interface
Parameters:
- `ACC_W`, default 32: signed width of each lane's group accumulator; legal range 26..40.
- `SHIFT_W`, default 5: width of the requant shift amount.

Ports:
- `clk`, in, 1: the only clock; all state updates on its rising edge.
- `clr`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: input beat can be accepted.
- `in_first`, in, 1: beat is the first of a group; the accumulator restarts from this beat.
- `in_last`, in, 1: beat is the last of a group; triggers requantization.
- `result_h`, in, 37: MAC upper result word.
- `result_l`, in, 38: MAC lower result word.
- `cfg_bias`, in, 3*ACC_W: per-lane signed bias; lane i is at `[ACC_W*i +: ACC_W]`.
- `cfg_mult`, in, 16: unsigned requant multiplier.
- `cfg_shift`, in, SHIFT_W: arithmetic right-shift amount.
- `cfg_relu`, in, 1: clamp negative results to 0.
- `out_valid`, out, 1: output FIFO head valid.
- `out_ready`, in, 1: consumer accepts the head.
- `out_data`, out, 24: `{lane2, lane1, lane0}`, each signed INT8.
- `out_sat`, out, 3: per-lane flag; 1 if the lane saturated anywhere in the group (accumulate, bias add or final clamp).

## Operation
- Beat accepted when `in_valid && in_ready`.
- Lane unpack, each lane 25-bit signed, sign-extended to ACC_W:
  - lane0 = `result_l[24:0]`
  - lane1 = `{result_h[11:0], result_l[37:25]}`
  - lane2 = `result_h[36:12]`
- Accumulate stage, on an accepted beat:
  - `acc[i] <= sat_ACC_W((in_first ? 0 : acc[i]) + lane[i])`.
  - Sticky `accsat[i] <= (in_first ? 0 : accsat[i]) | overflow`.
  - `in_first && in_last` in the same beat is a legal single-beat group.
  - A beat without `in_first` continues the current group; after reset, `acc` is 0.
- R1 stage, the cycle after an accepted last beat:
  - `s[i] = sat_ACC_W(acc[i] + bias[i])`; overflow sets the lane's sat flag.
  - `p[i] = s[i] * $signed({1'b0, cfg_mult})`, ACC_W+17 bits, exact.
- R2 stage:
  - `r[i] = (p[i] + (cfg_shift != 0 ? 1 << (cfg_shift-1) : 0)) >>> cfg_shift`, i.e. round half toward +inf.
  - If `cfg_relu`, then `r = max(r, 0)`.
  - Clamp to [-128, 127]; a clamp that changes the value sets the sat flag. ReLU alone does not set it.
  - Push `{data, sat}` into the FIFO.
- `cfg_*` are sampled in R1 (bias, mult) and R2 (shift, relu) for the group in flight. Config must be stable from the last beat's acceptance until its FIFO push; otherwise the result is undefined.
- Credit flow control:
  - `credits = 2 - fifo_count - inflight`, where `inflight` counts last beats currently in R1/R2.
  - `in_ready = !clr && credits != 0`, combinational from registered state.
  - A FIFO pop in the same cycle does not raise `in_ready` until the next cycle.
- FIFO: depth 2, first-in first-out.
  - Simultaneous push and pop at count 2 is impossible by credits.
  - Simultaneous push and pop at count 1 keeps count 1.

## Timing
- Reset (`clr` high at an edge) clears `acc`, the sticky flags, R1/R2 valids and the FIFO. It discards any partially accumulated group and in-flight results.
- Outputs while `clr` is high and after reset: `in_ready=0` while `clr` is high, 1 from the first cycle `clr` is low. `out_valid=0`, `out_data=0`, `out_sat=0`.
- Latency: last beat accepted in cycle T gives `out_valid=1` in cycle T+3 if the FIFO was empty.
- Throughput: one beat per cycle while credits allow. Sustained single-beat groups with `out_ready=1` run 1 group / 2 cycles at minimum; `in_ready` drops while 2 groups are outstanding.
- `out_data`/`out_sat` are held stable while `out_valid && !out_ready`.

## Test plan
- Single-beat group: lanes (100, -50, 3), bias 0, mult 1, shift 0, relu 0 -> `out_data=0x03CE64` at T+3, `out_sat=0`.
- Three-beat group: lane0 = 10, 20, 30 with first on beat 1 and last on beat 3; bias 40, mult 2, shift 1 -> lane0 = 100 (0x64); no output before the last beat.
- Rounding/ReLU: acc (300, -300, 4), mult 3, shift 3 -> lanes (113, -112, 2); with relu=1 -> (113, 0, 2).
- Saturation (ACC_W=26): lane0 = 16777215 for 3 beats, mult 1, shift 0 -> acc saturates at 33554431; `out_data[7:0]=0x7F`, `out_sat[0]=1`; other lanes 0, flags 0.
- Backpressure: `out_ready=0`, 3 single-beat groups offered back-to-back -> 2 accepted, `in_ready=0`. Raise `out_ready` -> outputs in order, third group accepted after the first pop.
- Reset mid-group: 2 beats of 50 without last, `clr` for 1 cycle, then a single-beat group of 7 -> output 7 (stale 100 discarded); all outputs are 0 during reset.
